// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 mux select and a
// valid/ready output port; each grant is capped at MAX_BURST transfers while the other side waits.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_A = 2'd1,
        ST_SERVE_B = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);
    localparam logic       LP_SIDE_A    = 1'b0;
    localparam logic       LP_SIDE_B    = 1'b1;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_sel;
    logic       r_last;
    logic       w_last_nxt;
    logic [3:0] r_burst_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_cnt_inc;
    logic       w_own_req;
    logic       w_other_req;
    logic       w_xfer;
    state_t     w_other_state;
    logic       w_other_side;

    // Requests seen from the point of view of whichever side currently holds the grant.
    always_comb begin
        w_own_req     = 1'b0;
        w_other_req   = 1'b0;
        w_other_state = ST_IDLE;
        w_other_side  = LP_SIDE_A;
        case (r_state)
            ST_SERVE_A: begin
                w_own_req     = req_a;
                w_other_req   = req_b;
                w_other_state = ST_SERVE_B;
                w_other_side  = LP_SIDE_B;
            end
            ST_SERVE_B: begin
                w_own_req     = req_b;
                w_other_req   = req_a;
                w_other_state = ST_SERVE_A;
                w_other_side  = LP_SIDE_A;
            end
            default: ;
        endcase
    end

    assign out_valid = !rst && w_own_req;
    assign w_xfer    = out_valid && out_ready;
    assign ack_a     = w_xfer && (r_state == ST_SERVE_A);
    assign ack_b     = w_xfer && (r_state == ST_SERVE_B);
    assign w_cnt_inc = r_burst_cnt + 4'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which is what keeps latches from being inferred.
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                // On a tie the side that was not granted last wins.
                if (req_a && (!req_b || r_last == LP_SIDE_B)) begin
                    w_state_nxt = ST_SERVE_A;
                    w_last_nxt  = LP_SIDE_A;
                    w_cnt_nxt   = 4'd0;
                end else if (req_b) begin
                    w_state_nxt = ST_SERVE_B;
                    w_last_nxt  = LP_SIDE_B;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_SERVE_A, ST_SERVE_B: begin
                if (w_xfer) begin
                    if (w_cnt_inc == LP_MAX_BURST) begin
                        w_cnt_nxt = 4'd0;
                        if (w_other_req) begin
                            w_state_nxt = w_other_state;
                            w_last_nxt  = w_other_side;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else if (!w_own_req) begin
                    w_cnt_nxt = 4'd0;
                    if (w_other_req) begin
                        w_state_nxt = w_other_state;
                        w_last_nxt  = w_other_side;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_last      <= LP_SIDE_B;
            r_burst_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= (w_state_nxt == ST_SERVE_B);
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    assign sel      = r_sel;
    assign busy     = (r_state != ST_IDLE);
    assign out_data = r_sel ? data_b : data_a;

    burst_cnt_in_range : assert property (@(posedge clk) disable iff (rst)
        r_burst_cnt < LP_MAX_BURST);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a per-cycle vector table plus hand-built
// sequences for single-requester streaming, tie-break after a B grant and reset in SERVE_B.
module tb_mux2_rr_arbiter;

    typedef struct {
        logic       rst;
        logic       ra;
        logic       rb;
        logic [1:0] da;
        logic [1:0] db;
        logic       rdy;
        logic       e_sel;
        logic       e_val;
        logic       e_aa;
        logic       e_ab;
        logic [1:0] e_od;
        logic       e_busy;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic [1:0] data_a;
    logic       ack_a;
    logic       req_b;
    logic [1:0] data_b;
    logic       ack_b;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       sel;
    logic       busy;

    int total = 0;
    int bad   = 0;

    mux2_rr_arbiter #(.WIDTH(2), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1);
    end

    function automatic vec_t mk(input logic r, input logic ra, input logic rb,
                                input logic [1:0] da, input logic [1:0] db, input logic rdy,
                                input logic s, input logic v, input logic aa, input logic ab,
                                input logic [1:0] od, input logic bz);
        vec_t t;
        t.rst = r;   t.ra = ra;   t.rb = rb;   t.da = da;   t.db = db;   t.rdy = rdy;
        t.e_sel = s; t.e_val = v; t.e_aa = aa; t.e_ab = ab; t.e_od = od; t.e_busy = bz;
        return t;
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and compare shortly after.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst       = v.rst;
        req_a     = v.ra;
        req_b     = v.rb;
        data_a    = v.da;
        data_b    = v.db;
        out_ready = v.rdy;
        #1;
        check({tag, " sel"},       {1'b0, sel},       {1'b0, v.e_sel});
        check({tag, " out_valid"}, {1'b0, out_valid}, {1'b0, v.e_val});
        check({tag, " ack_a"},     {1'b0, ack_a},     {1'b0, v.e_aa});
        check({tag, " ack_b"},     {1'b0, ack_b},     {1'b0, v.e_ab});
        check({tag, " out_data"},  out_data,          v.e_od);
        check({tag, " busy"},      {1'b0, busy},      {1'b0, v.e_busy});
    endtask

    vec_t tbl[$];

    initial begin
        //                 rst ra rb da db rdy | sel val aa ab od busy
        tbl.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));  // reset state
        tbl.push_back(mk(0, 1, 0, 2, 1, 1,  0, 0, 0, 0, 2, 0));  // A requests from IDLE
        tbl.push_back(mk(0, 1, 0, 2, 1, 1,  0, 1, 1, 0, 2, 1));  // granted next cycle
        tbl.push_back(mk(0, 0, 0, 2, 1, 1,  0, 0, 0, 0, 2, 1));  // A drops req
        tbl.push_back(mk(0, 0, 0, 0, 3, 1,  0, 0, 0, 0, 0, 0));  // back in IDLE
        tbl.push_back(mk(1, 1, 1, 1, 2, 1,  0, 0, 0, 0, 1, 0));  // reset, last=B
        tbl.push_back(mk(0, 1, 1, 1, 2, 1,  0, 0, 0, 0, 1, 0));  // tie -> A
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 1, 2, 1,  0, 1, 1, 0, 1, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 1, 2, 1,  1, 1, 0, 1, 2, 1));
        tbl.push_back(mk(0, 1, 1, 1, 2, 1,  0, 1, 1, 0, 1, 1));  // back to A, no gap
        tbl.push_back(mk(0, 0, 0, 1, 2, 1,  0, 0, 0, 0, 1, 1));  // both drop
        tbl.push_back(mk(0, 1, 0, 3, 0, 0,  0, 0, 0, 0, 3, 0));  // A requests, consumer stalled
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 1, 1, 3, 0, 0,  0, 1, 0, 0, 3, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, 1, 3, 0, 1,  0, 1, 1, 0, 3, 1));
        tbl.push_back(mk(0, 1, 1, 3, 0, 1,  1, 1, 0, 1, 0, 1));  // full burst then B

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        data_a = 2'd0; data_b = 2'd0; out_ready = 1'b0;
        @(posedge clk);

        foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

        // Reset while B holds the grant, then B streams alone for 10 transfers.
        apply(mk(1, 0, 0, 0, 1, 1,  1, 0, 0, 0, 1, 1), "rstB");
        apply(mk(0, 0, 1, 0, 2, 1,  0, 0, 0, 0, 0, 0), "bonly_req");
        for (int i = 0; i < 10; i++) begin
            logic [1:0] d;
            d = 2'(i);
            apply(mk(0, 0, 1, 0, d, 1,  1, 1, 0, 1, d, 1), $sformatf("bonly%0d", i));
        end
        apply(mk(0, 0, 0, 2, 1, 1,  1, 0, 0, 0, 1, 1), "bonly_drop");

        // Idle after a B grant, then a tie: A must win.
        apply(mk(0, 0, 0, 2, 1, 1,  0, 0, 0, 0, 2, 0), "idle_after_b");
        apply(mk(0, 1, 1, 2, 1, 1,  0, 0, 0, 0, 2, 0), "tie_req");
        apply(mk(0, 1, 1, 2, 1, 1,  0, 1, 1, 0, 2, 1), "tie_grant_a");

        // A releases, B takes over, then reset lands during SERVE_B.
        apply(mk(0, 0, 1, 2, 3, 1,  0, 0, 0, 0, 2, 1), "a_release");
        apply(mk(1, 1, 1, 2, 3, 1,  1, 0, 0, 0, 3, 1), "rst_in_b");
        apply(mk(0, 1, 1, 2, 3, 1,  0, 0, 0, 0, 2, 0), "post_rst_idle");
        apply(mk(0, 1, 1, 2, 3, 1,  0, 1, 1, 0, 2, 1), "post_rst_a");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
